// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit FIFO controller: circular byte queue feeding a three-state
// start/wait handshake toward the UART transmitter.
module uart_tx_fifo_ctrl #(
   parameter int MAX_UART_DATA_W = 8,
   parameter int FIFO_DEPTH      = 8,
   parameter int NEARLY_THRESH   = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            fifo_en_i,
   input  logic                            push_i,
   input  logic [MAX_UART_DATA_W-1:0]      push_data_i,
   input  logic                            flush_i,
   input  logic                            tx_en_i,
   input  logic                            tx_busy_i,
   input  logic                            tx_done_i,
   output logic                            tx_start_o,
   output logic [MAX_UART_DATA_W-1:0]      tx_data_o,
   output logic                            full_o,
   output logic                            nearly_full_o,
   output logic                            empty_o,
   output logic                            nearly_empty_o,
   output logic                            overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]     level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] NF_L    = (AW+1)'(FIFO_DEPTH - NEARLY_THRESH);
   localparam logic [AW:0] NE_L    = (AW+1)'(NEARLY_THRESH);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t                     state, state_n;
   logic [MAX_UART_DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]              wr_ptr, rd_ptr;
   logic [AW:0]                cnt;
   logic                       push_ok, pop;

   // Flags come straight from the registered count, so they lag a push by one edge.
   assign full_o         = (cnt == DEPTH_L);
   assign empty_o        = (cnt == '0);
   assign nearly_full_o  = (cnt >= NF_L);
   assign nearly_empty_o = (cnt <= NE_L);
   assign level_o        = cnt;

   // No same-cycle pop credit: a push at full is dropped even if a pop happens.
   // A flush discards everything, so it also suppresses the push.
   assign push_ok = push_i && !full_o && !flush_i;
   // A flush in the launch cycle cancels the launch: the head entry is discarded.
   assign pop     = (state == IDLE) && fifo_en_i && tx_en_i && !empty_o &&
                    !tx_busy_i && !flush_i;

   // Byte storage; contents survive reset since the count defines validity.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= push_data_i;
   end

   // Pointers and count; flush clears all of them and wins over push/pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Overflow pulse one cycle after a dropped push; a push masked by flush is not an overflow.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) overflow_o <= 1'b0;
      else         overflow_o <= push_i && full_o && !flush_i;
   end

   // Transmit byte is captured at pop time and held until the next pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)  tx_data_o <= '0;
      else if (pop) tx_data_o <= mem[rd_ptr];
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_n;
   end

   // Next state and start strobe; tx_done_i only matters in WAIT.
   always_comb begin
      state_n    = state;
      tx_start_o = 1'b0;
      case (state)
         IDLE:  if (pop) state_n = START;
         START: begin
            tx_start_o = 1'b1;
            state_n    = tx_en_i ? WAIT : IDLE;
         end
         WAIT:  if (!tx_en_i || tx_done_i) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench: stimulus queues the bytes expected on the transmitter,
// a negedge monitor checks every tx_start_o strobe against that queue.
module tb_uart_tx_fifo_ctrl;

   localparam int W = 8;
   localparam int D = 8;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         fifo_en_i = 1'b0, push_i = 1'b0, flush_i = 1'b0;
   logic         tx_en_i = 1'b0, tx_busy_i = 1'b0, tx_done_i = 1'b0;
   logic [W-1:0] push_data_i = '0;
   logic         tx_start_o, full_o, nearly_full_o, empty_o, nearly_empty_o, overflow_o;
   logic [W-1:0] tx_data_o;
   logic [3:0]   level_o;

   uart_tx_fifo_ctrl #(.MAX_UART_DATA_W(W), .FIFO_DEPTH(D), .NEARLY_THRESH(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .fifo_en_i(fifo_en_i), .push_i(push_i),
      .push_data_i(push_data_i), .flush_i(flush_i), .tx_en_i(tx_en_i),
      .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i), .tx_start_o(tx_start_o),
      .tx_data_o(tx_data_o), .full_o(full_o), .nearly_full_o(nearly_full_o),
      .empty_o(empty_o), .nearly_empty_o(nearly_empty_o), .overflow_o(overflow_o),
      .level_o(level_o)
   );

   always #5 clk_i = ~clk_i;

   int         n_cmp = 0, n_err = 0;
   int         cyc = 0, n_starts = 0, n_ovf = 0, last_start = -100;
   logic [W-1:0] exp_q [$];

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: each start strobe must match the oldest expected byte and be
   // at least three cycles after the previous one (START, WAIT, IDLE).
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (overflow_o) n_ovf++;
         if (tx_start_o) begin
            n_starts++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_start: got data 0x%0h expected no start", tx_data_o);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               if (tx_data_o !== e) begin
                  n_err++;
                  $display("FAIL tx_data: got 0x%0h expected 0x%0h", tx_data_o, e);
               end
            end
            n_cmp++;
            if (cyc - last_start < 3) begin
               n_err++;
               $display("FAIL start_gap: got %0d cycles expected >= 3", cyc - last_start);
            end
            last_start = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [W-1:0] d, input bit exp_tx);
      push_i = 1'b1;
      push_data_i = d;
      if (exp_tx) exp_q.push_back(d);
      tick();
      push_i = 1'b0;
   endtask

   task automatic wait_start();
      int t = 0;
      while (!tx_start_o && t < 50) begin
         tick();
         t++;
      end
      if (!tx_start_o) begin
         n_cmp++;
         n_err++;
         $display("FAIL start_timeout: got no tx_start_o expected one within 50 cycles");
      end
   endtask

   // Run one frame to completion: start, two WAIT cycles, done pulse.
   task automatic serve_frame();
      wait_start();
      tick();
      tick();
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
   endtask

   initial begin
      int s0;
      #3;
      chk("rst_tx_start", tx_start_o, 0);
      chk("rst_tx_data", tx_data_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_nearly_empty", nearly_empty_o, 1);
      chk("rst_full", full_o, 0);
      chk("rst_nearly_full", nearly_full_o, 0);
      chk("rst_overflow", overflow_o, 0);
      chk("rst_level", level_o, 0);
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_ni = 1'b1;
      tick();

      // Two bytes in order, separated by an IDLE cycle
      fifo_en_i = 1'b1; tx_en_i = 1'b1;
      push(8'hA5, 1);
      push(8'h3C, 1);
      serve_frame();
      serve_frame();
      chk("t1_empty", empty_o, 1);
      chk("t1_level", level_o, 0);

      // Fill past depth with popping disabled
      fifo_en_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         push(8'h10 + 8'(i), i < 8);
         if (i == 1) chk("t2_nearly_empty_l2", nearly_empty_o, 1);
         if (i == 2) chk("t2_nearly_empty_l3", nearly_empty_o, 0);
         if (i == 4) chk("t2_nearly_full_l5", nearly_full_o, 0);
         if (i == 5) begin
            chk("t2_nearly_full_l6", nearly_full_o, 1);
            chk("t2_full_l6", full_o, 0);
            chk("t2_level_l6", level_o, 6);
         end
         if (i == 7) begin
            chk("t2_full_l8", full_o, 1);
            chk("t2_level_l8", level_o, 8);
            chk("t2_no_ovf_yet", overflow_o, 0);
         end
      end
      chk("t2_ovf_pulse", overflow_o, 1);
      chk("t2_level_after_drop", level_o, 8);
      tick();
      chk("t2_ovf_one_cycle", overflow_o, 0);
      fifo_en_i = 1'b1;
      repeat (8) serve_frame();
      chk("t2_drained", empty_o, 1);

      // Same-cycle push/pop at level 3, then 20-byte wrap-around stream
      fifo_en_i = 1'b0;
      push(8'h20, 1); push(8'h21, 1); push(8'h22, 1);
      chk("t3_level3", level_o, 3);
      fifo_en_i = 1'b1;
      push(8'h23, 1);
      chk("t3_pushpop_level", level_o, 3);
      chk("t3_pushpop_start", tx_start_o, 1);
      serve_frame();
      for (int i = 4; i < 20; i++) begin
         push(8'h20 + 8'(i), 1);
         serve_frame();
      end
      chk("t3_level_stream", level_o, 3);
      repeat (3) serve_frame();
      chk("t3_drained", empty_o, 1);

      // tx_en_i dropped in WAIT aborts the frame without requeue
      fifo_en_i = 1'b0;
      push(8'h55, 1);
      push(8'h66, 0);
      fifo_en_i = 1'b1;
      wait_start();
      tick();
      tx_en_i = 1'b0;
      tick();
      s0 = n_starts;
      chk("t4_level_after_abort", level_o, 1);
      repeat (4) tick();
      chk("t4_no_more_starts", n_starts, s0);
      flush_i = 1'b1; tick(); flush_i = 1'b0;
      chk("t4_flush_level", level_o, 0);
      tx_en_i = 1'b1;
      push(8'h5A, 1);  // starts without tx_done, so the abort left the FSM in IDLE
      serve_frame();

      // Flush together with push during WAIT at level 5
      fifo_en_i = 1'b0;
      for (int i = 0; i < 6; i++) push(8'h70 + 8'(i), i == 0);
      chk("t5_level6", level_o, 6);
      fifo_en_i = 1'b1;
      wait_start();
      chk("t5_level5", level_o, 5);
      tick();
      flush_i = 1'b1;
      push(8'h99, 0);
      flush_i = 1'b0;
      chk("t5_flush_level", level_o, 0);
      chk("t5_no_ovf", overflow_o, 0);
      s0 = n_starts;
      push(8'h77, 1);
      repeat (3) tick();
      chk("t5_frame_still_waiting", n_starts, s0);
      tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
      serve_frame();
      chk("t5_drained", empty_o, 1);

      // Asynchronous reset during START
      push(8'h88, 1);
      wait_start();
      @(negedge clk_i); #1;
      rst_ni = 1'b0;
      #1;
      chk("t6_tx_start", tx_start_o, 0);
      chk("t6_tx_data", tx_data_o, 0);
      chk("t6_empty", empty_o, 1);
      chk("t6_nearly_empty", nearly_empty_o, 1);
      chk("t6_full", full_o, 0);
      chk("t6_nearly_full", nearly_full_o, 0);
      chk("t6_overflow", overflow_o, 0);
      chk("t6_level", level_o, 0);

      chk("end_queue_empty", exp_q.size(), 0);
      chk("end_overflow_count", n_ovf, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
